// File: rtl/main_memory_responder.sv
// Word-addressed main memory that answers processor read/write requests after a fixed wait.
// Optional MAIN_MEMORY_ALIGN_CHECK_EN: misaligned byte addresses complete with Error and no access.
module main_memory_responder #(
  parameter int unsigned DATAWIDTH_BUS      = 32,
  parameter int unsigned DATAWIDTH_MEM_ADDR = 10,
  parameter int unsigned WAIT_STATES        = 2
) (
  input  logic                     MainMemory_CLOCK_50,
  input  logic                     MainMemory_Reset_InHigh,
  input  logic                     MainMemory_RD_InHigh,
  input  logic                     MainMemory_WR_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] MainMemory_Address,
  input  logic [DATAWIDTH_BUS-1:0] MainMemory_DataIn,
  output logic [DATAWIDTH_BUS-1:0] MainMemory_DataOut,
  output logic                     MainMemory_MFC_OutHigh,
  output logic                     MainMemory_Error_OutHigh
);

  localparam int unsigned DEPTH = 1 << DATAWIDTH_MEM_ADDR;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [CNT_W-1:0]              r_cnt;
  logic [DATAWIDTH_MEM_ADDR-1:0] r_idx;
  logic [DATAWIDTH_BUS-1:0]      r_data;
  logic                          r_is_rd;
  logic                          r_is_wr;
  logic                          r_bad;
  logic                          r_mfc;
  logic                          r_err;
  logic [DATAWIDTH_BUS-1:0]      r_dout;
  logic [DATAWIDTH_BUS-1:0]      r_mem [DEPTH];

  logic w_rd;
  logic w_wr;
  logic w_one_req;
  logic w_both_req;
  logic w_misalign;
  logic w_err_next;
  logic w_unused_addr;

  assign w_rd       = MainMemory_RD_InHigh;
  assign w_wr       = MainMemory_WR_InHigh;
  assign w_one_req  = w_rd ^ w_wr;
  assign w_both_req = w_rd & w_wr;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  assign w_misalign = |MainMemory_Address[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  // Upper address bits wrap modulo depth; low byte-offset bits only matter for the alignment check.
  assign w_unused_addr = ^{MainMemory_Address[DATAWIDTH_BUS-1:DATAWIDTH_MEM_ADDR+2],
                           MainMemory_Address[1:0]};

  // Next-state and completion-error decode.
  always_comb begin
    w_next     = r_state;
    w_err_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_one_req) begin
          w_next = S_WAIT;
        end else if (w_both_req) begin
          w_next     = S_DONE;
          w_err_next = 1'b1;
        end
      end
      S_WAIT: begin
        w_err_next = r_bad;
        if (r_cnt <= CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!w_rd && !w_wr) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, request capture, wait counter and registered outputs.
  always_ff @(posedge MainMemory_CLOCK_50) begin
    if (MainMemory_Reset_InHigh) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_is_rd <= 1'b0;
      r_is_wr <= 1'b0;
      r_bad   <= 1'b0;
      r_mfc   <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      r_mfc   <= (w_next == S_DONE);
      r_err   <= (w_next == S_DONE) ? w_err_next : 1'b0;

      if (r_state == S_IDLE && (w_rd || w_wr)) begin
        r_idx   <= MainMemory_Address[DATAWIDTH_MEM_ADDR+1:2];
        r_data  <= MainMemory_DataIn;
        r_is_rd <= w_rd & ~w_wr;
        r_is_wr <= w_wr & ~w_rd;
        r_bad   <= w_both_req | w_misalign;
      end

      if (r_state == S_IDLE && w_next == S_WAIT) begin
        r_cnt <= CNT_W'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // Read data lands together with MFC.
      if (r_state == S_WAIT && w_next == S_DONE && r_is_rd && !r_bad) begin
        r_dout <= r_mem[r_idx];
      end
    end
  end

  // Write commits on the edge closing DONE; a reset edge aborts it. Contents survive reset.
  always_ff @(posedge MainMemory_CLOCK_50) begin
    if (!MainMemory_Reset_InHigh && r_state == S_DONE && r_is_wr && !r_bad) begin
      r_mem[r_idx] <= r_data;
    end
  end

  assign MainMemory_DataOut       = r_dout;
  assign MainMemory_MFC_OutHigh   = r_mfc;
  assign MainMemory_Error_OutHigh = r_err;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed self-checking bench for main_memory_responder (default parameters, WAIT_STATES=2).
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        mfc;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  main_memory_responder #(
    .DATAWIDTH_BUS     (32),
    .DATAWIDTH_MEM_ADDR(10),
    .WAIT_STATES       (2)
  ) dut (
    .MainMemory_CLOCK_50     (clk),
    .MainMemory_Reset_InHigh (rst),
    .MainMemory_RD_InHigh    (rd),
    .MainMemory_WR_InHigh    (wr),
    .MainMemory_Address      (addr),
    .MainMemory_DataIn       (din),
    .MainMemory_DataOut      (dout),
    .MainMemory_MFC_OutHigh  (mfc),
    .MainMemory_Error_OutHigh(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request; lat counts edges from the sampling edge (1) until MFC is seen.
  task automatic request(input logic i_rd, input logic i_wr, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble,
                         output int lat, output logic e, output logic [31:0] dq);
    rd = i_rd; wr = i_wr; addr = a; din = d;
    lat = -1; e = 1'b0; dq = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (scramble && k == 1) begin
        addr = a ^ 32'h30;
        din  = ~d;
      end
      if (mfc) begin
        lat = k; e = err; dq = dout;
        break;
      end
    end
  endtask

  // Keep the request asserted n cycles counting MFC/Error, then release and settle in IDLE.
  task automatic hold_release(input int n, output int mcnt, output int ecnt);
    mcnt = 0; ecnt = 0;
    repeat (n) begin
      tick();
      if (mfc) mcnt++;
      if (err) ecnt++;
    end
    rd = 1'b0; wr = 1'b0;
    tick();
    tick();
  endtask

  int          lat;
  int          mc;
  int          ec;
  logic        e;
  logic [31:0] dq;
  logic        exp_mis_err;
  logic [31:0] exp_mis_word;

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_mfc",  32'(mfc),  32'd0);
    check("reset_err",  32'(err),  32'd0);
    check("reset_dout", dout,      32'd0);

    request(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, e, dq);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_err",     32'(e),   32'd0);
    check("wr_dout",    dq,       32'd0);
    hold_release(4, mc, ec);
    check("wr_hold_no_mfc", 32'(mc), 32'd0);
    check("wr_hold_no_err", 32'(ec), 32'd0);

    request(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat, e, dq);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_err",     32'(e),   32'd0);
    check("rd_data",    dq,       32'hDEADBEEF);
    hold_release(2, mc, ec);
    check("rd_hold_no_mfc", 32'(mc), 32'd0);
    check("rd_dout_kept",   dout,    32'hDEADBEEF);

    request(1'b1, 1'b1, 32'h10, 32'h11111111, 1'b0, lat, e, dq);
    check("both_latency", 32'(lat), 32'd1);
    check("both_err",     32'(e),   32'd1);
    check("both_dout",    dq,       32'hDEADBEEF);
    hold_release(3, mc, ec);
    check("both_err_one_cycle", 32'(ec), 32'd0);
    request(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, dq);
    check("both_mem_unchanged", dq, 32'hDEADBEEF);
    hold_release(1, mc, ec);

    request(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, lat, e, dq);
    hold_release(1, mc, ec);

    // Reset lands on the edge that would have entered DONE.
    wr = 1'b1; addr = 32'h20; din = 32'hCAFEF00D;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_mfc", 32'(mfc), 32'd0);
    rst = 1'b0; wr = 1'b0;
    mc = 0;
    repeat (5) begin
      tick();
      if (mfc) mc++;
    end
    check("abort_no_late_mfc", 32'(mc), 32'd0);
    check("abort_dout_reset",  dout,    32'd0);
    request(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, dq);
    check("abort_prior_data", dq, 32'hAAAA5555);
    hold_release(1, mc, ec);

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    exp_mis_err  = 1'b1;
    exp_mis_word = 32'hAAAA5555;
`else
    exp_mis_err  = 1'b0;
    exp_mis_word = 32'h5A5A5A5A;
`endif
    request(1'b0, 1'b1, 32'h22, 32'h5A5A5A5A, 1'b0, lat, e, dq);
    check("mis_latency", 32'(lat), 32'd3);
    check("mis_err",     32'(e),   32'(exp_mis_err));
    hold_release(1, mc, ec);
    request(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, dq);
    check("mis_word20", dq, exp_mis_word);
    hold_release(1, mc, ec);

    request(1'b0, 1'b1, 32'h1010, 32'h12345678, 1'b0, lat, e, dq);
    hold_release(1, mc, ec);
    request(1'b1, 1'b0, 32'h0010, 32'h0, 1'b0, lat, e, dq);
    check("wrap_latency", 32'(lat), 32'd3);
    check("wrap_data",    dq,       32'h12345678);
    hold_release(1, mc, ec);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: data bus width in bits.
REQ-002 Parameter DATAWIDTH_MEM_ADDR, default 10: word-index width; memory depth is 2^DATAWIDTH_MEM_ADDR words.
REQ-003 Parameter WAIT_STATES, default 2, legal range 0..15: cycles spent in WAIT before MFC.
REQ-004 MainMemory_CLOCK_50  in  1  single clock; all logic SHALL act on its rising edge.
REQ-005 MainMemory_Reset_InHigh  in  1  reset, synchronous, active-high.
REQ-006 MainMemory_RD_InHigh  in  1  read request from the processor control unit.
REQ-007 MainMemory_WR_InHigh  in  1  write request from the processor control unit.
REQ-008 MainMemory_Address  in  DATAWIDTH_BUS  byte address from the datapath.
REQ-009 MainMemory_DataIn  in  DATAWIDTH_BUS  write data.
REQ-010 MainMemory_DataOut  out  DATAWIDTH_BUS  read data, registered.
REQ-011 MainMemory_MFC_OutHigh  out  1  memory-function-complete pulse.
REQ-012 MainMemory_Error_OutHigh  out  1  request error flag, valid with MFC.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, DONE, HOLD.
REQ-014 IDLE: the block SHALL capture address, data and request type, then go to WAIT, when exactly one of RD/WR is high.
REQ-015 IDLE: if RD and WR are both high, the block SHALL perform no access, go to DONE, and set Error with MFC.
REQ-016 WAIT: a counter SHALL load WAIT_STATES on entry and decrement each cycle; the FSM SHALL go to DONE when the counter reaches 0; with WAIT_STATES=0, WAIT SHALL last exactly 1 cycle.
REQ-017 DONE: MFC SHALL be high for exactly one cycle; Error SHALL be valid only during that cycle.
REQ-018 On the DONE cycle a read SHALL present mem[word index] on DataOut; a write SHALL update mem at the DONE clock edge.
REQ-019 Latency: request sampled at edge N, MFC high during cycle N+1+max(WAIT_STATES,1).
REQ-020 Word index SHALL be Address[DATAWIDTH_MEM_ADDR+1:2]; upper address bits SHALL be ignored (wrap-around modulo depth).
REQ-021 After DONE, the FSM SHALL go to HOLD; HOLD SHALL return to IDLE only when RD=WR=0 on a sampled edge, so a held request is never serviced twice.
REQ-022 DataOut SHALL hold its last read value until the next read completes; writes SHALL NOT change DataOut.
REQ-023 RD/WR/Address/DataIn changes during WAIT SHALL be ignored; captured values SHALL be used.
REQ-024 A read-after-write to the same word SHALL return the newly written data.

Reset
REQ-025 On reset: FSM=IDLE, counter=0, MFC=0, Error=0, DataOut=0.
REQ-026 Reset during WAIT or DONE SHALL abort the transaction; no memory write SHALL occur on the reset edge.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MAIN_MEMORY_ALIGN_CHECK_EN defined: a request with Address[1:0]!=0 SHALL skip the access (no write, DataOut unchanged) and complete through WAIT to DONE with Error=1.
REQ-029 Macro undefined: Address[1:0] SHALL be ignored, and Error SHALL assert only for simultaneous RD/WR.

Verification
REQ-030 Reset, WR=1, Address=0x10, DataIn=0xDEADBEEF, WAIT_STATES=2 -> MFC high 3 cycles after the sample edge, Error=0; hold WR 4 more cycles -> no second MFC.
REQ-031 After REQ-030, drop WR, RD=1, Address=0x10 -> MFC one cycle with DataOut=0xDEADBEEF; DataOut stays 0xDEADBEEF after RD drops.
REQ-032 RD=WR=1 -> MFC and Error high for one cycle, memory unchanged, DataOut unchanged.
REQ-033 Depth 1024: write 0x12345678 to Address=0x1010, read Address=0x0010 -> DataOut=0x12345678 (wrap).
REQ-034 Reset asserted during WAIT of a write of 0xCAFEF00D to 0x20 -> MFC never asserts; subsequent read of 0x20 returns the prior contents.
REQ-035 With MAIN_MEMORY_ALIGN_CHECK_EN, WR to Address=0x22 -> Error=1 with MFC, word 0x20 unchanged; without the macro -> word 0x20 written, Error=0.
